ram_port_arbiter: RTL and testbench

//  Shares one port of dp_ram between two requesters (R0, R1) with round-robin

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_port_arbiter.sv | 116 +++++++++++
 tb/tb_ram_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for ram_port_arbiter: arbiter FSM states and requester indices.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int RQ0 = 0;
    localparam int RQ1 = 1;

    function automatic logic other_rq(input logic rq);
        return ~rq;
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for one dp_ram port, with lock for bursts
// and routing of the 1-cycle synchronous read data back to the reader.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int P_DATA_W         = 7,
    parameter int P_LOG2_RAM_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [1:0]                  i_req,
    input  logic [1:0]                  i_lock,
    input  logic [1:0]                  i_wr,
    input  logic [P_LOG2_RAM_DEPTH-1:0] i_addr0,
    input  logic [P_LOG2_RAM_DEPTH-1:0] i_addr1,
    input  logic [P_DATA_W-1:0]         i_data0,
    input  logic [P_DATA_W-1:0]         i_data1,
    output logic [1:0]                  o_gnt,
    output logic [1:0]                  o_rvalid,
    output logic [P_DATA_W-1:0]         o_rdata,
    output logic                        o_ram_wr,
    output logic [P_LOG2_RAM_DEPTH-1:0] o_ram_addr,
    output logic [P_DATA_W-1:0]         o_ram_data,
    input  logic [P_DATA_W-1:0]         i_ram_data
);

    arb_state_e state, state_nxt;
    logic       en;
    logic       prio, prio_nxt;
    logic [1:0] gnt;
    logic [1:0] rd_tag;

    logic [1:0][P_LOG2_RAM_DEPTH-1:0] addr_v;
    logic [1:0][P_DATA_W-1:0]         data_v;

    assign addr_v = {i_addr1, i_addr0};
    assign data_v = {i_data1, i_data0};

    // Grant is only ever given to a requesting side, so gnt doubles as accept.
    always_comb begin
        gnt = '0;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (i_req == 2'b11) gnt[prio] = 1'b1;
                    else                gnt = i_req;
                end
                ST_OWN0: gnt[RQ0] = i_req[RQ0];
                ST_OWN1: gnt[RQ1] = i_req[RQ1];
                default: gnt = '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        case (state)
            ST_IDLE: begin
                if (gnt[RQ0]) begin
                    prio_nxt = other_rq(1'b0);
                    if (i_lock[RQ0]) state_nxt = ST_OWN0;
                end else if (gnt[RQ1]) begin
                    prio_nxt = other_rq(1'b1);
                    if (i_lock[RQ1]) state_nxt = ST_OWN1;
                end
            end
            // Owner leaves on its last locked-off access or when it stops asking.
            ST_OWN0: begin
                if (!(i_req[RQ0] && i_lock[RQ0])) begin
                    state_nxt = ST_IDLE;
                    prio_nxt  = other_rq(1'b0);
                end
            end
            ST_OWN1: begin
                if (!(i_req[RQ1] && i_lock[RQ1])) begin
                    state_nxt = ST_IDLE;
                    prio_nxt  = other_rq(1'b1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ram_wr   = 1'b0;
        o_ram_addr = '0;
        o_ram_data = '0;
        for (int n = 0; n < 2; n++) begin
            if (gnt[n]) begin
                o_ram_wr   = i_wr[n] & i_req[n];
                o_ram_addr = addr_v[n];
                o_ram_data = data_v[n];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en     <= 1'b0;
            state  <= ST_IDLE;
            prio   <= 1'b0;
            rd_tag <= '0;
        end else begin
            en     <= 1'b1;
            state  <= state_nxt;
            prio   <= prio_nxt;
            rd_tag <= gnt & ~i_wr;
        end
    end

    assign o_gnt    = gnt;
    assign o_rvalid = rd_tag;
    assign o_rdata  = (|rd_tag) ? i_ram_data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a behavioural single-port RAM attached and
// a per-cycle reference model plus directed literal expectations.
module tb_ram_port_arbiter;

    localparam int DW = 7;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = '0, lock = '0, wr = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic [1:0]    gnt, rvalid;
    logic [DW-1:0] rdata, ram_data, ram_q;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.P_DATA_W(DW), .P_LOG2_RAM_DEPTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lock(lock), .i_wr(wr),
        .i_addr0(addr0), .i_addr1(addr1), .i_data0(data0), .i_data1(data1),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_ram_wr(ram_wr), .o_ram_addr(ram_addr), .o_ram_data(ram_data),
        .i_ram_data(ram_q)
    );

    // dp_ram port stand-in: synchronous write, 1-cycle registered read
    logic [DW-1:0] ram_mem [16];
    initial begin
        ram_q = '0;
        for (int i = 0; i < 16; i++) ram_mem[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner/prio as requester numbers, memory as an array.
    int            m_owner = -1;
    int            m_prio  = 0;
    int            m_rd    = -1;
    bit            m_en    = 1'b0;
    logic [DW-1:0] m_rd_data = '0;
    logic [DW-1:0] m_mem [16];

    initial begin : model
        int            g;
        logic [1:0]    e_gnt, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data, e_rdata;
        logic          e_wr;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        forever begin
            @(negedge clk);
            g = -1;
            if (!rst_n) begin
                m_owner = -1; m_prio = 0; m_rd = -1; m_en = 1'b0;
            end else if (m_en) begin
                if (m_owner >= 0) begin
                    if (req[m_owner]) g = m_owner;
                end else if (req == 2'b11) g = m_prio;
                else if (req[0]) g = 0;
                else if (req[1]) g = 1;
            end
            e_gnt   = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
            e_addr  = (g == 0) ? addr0 : (g == 1) ? addr1 : '0;
            e_data  = (g == 0) ? data0 : (g == 1) ? data1 : '0;
            e_wr    = (g >= 0) ? wr[g] : 1'b0;
            e_rv    = (m_rd == 0) ? 2'b01 : (m_rd == 1) ? 2'b10 : 2'b00;
            e_rdata = (m_rd >= 0) ? m_rd_data : '0;
            chk("m_gnt", gnt, e_gnt);
            chk("m_rvalid", rvalid, e_rv);
            chk("m_rdata", rdata, e_rdata);
            chk("m_ram_wr", ram_wr, e_wr);
            chk("m_ram_addr", ram_addr, e_addr);
            chk("m_ram_data", ram_data, e_data);
            @(posedge clk);
            if (!rst_n) begin
                m_owner = -1; m_prio = 0; m_rd = -1; m_en = 1'b0;
            end else begin
                m_en = 1'b1;
                m_rd = -1;
                if (g >= 0) begin
                    if (e_wr) m_mem[e_addr] = e_data;
                    else begin m_rd = g; m_rd_data = m_mem[e_addr]; end
                end
                if (m_owner >= 0) begin
                    if (!req[m_owner] || !lock[m_owner]) begin
                        m_prio  = 1 - m_owner;
                        m_owner = -1;
                    end
                end else if (g >= 0) begin
                    m_prio = 1 - g;
                    if (lock[g]) m_owner = g;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [1:0] prev;
        // 1: reset, release, R0 write then read-back
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 2'b00);
            chk("rst_rvalid", rvalid, 2'b00);
            chk("rst_ram", {ram_wr, ram_addr, ram_data, rdata}, '0);
        end
        step();
        rst_n = 1'b1;
        req = 2'b01; wr = 2'b01; addr0 = 4'd2; data0 = 7'd5;
        @(negedge clk);
        chk("release_gnt", gnt, 2'b00);
        chk("release_ram", {ram_wr, ram_addr, ram_data, rdata, rvalid}, '0);
        step();
        @(negedge clk);
        chk("wr_gnt", gnt, 2'b01);
        chk("wr_ram", {ram_wr, ram_addr, ram_data}, {1'b1, 4'd2, 7'd5});
        step();
        wr = 2'b00;
        @(negedge clk);
        chk("rd_gnt", gnt, 2'b01);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("rd_rvalid", rvalid, 2'b01);
        chk("rd_rdata", rdata, 7'd5);
        // R1 access so that round robin hands R0 the first turn next
        step();
        req = 2'b10; addr1 = 4'd2;
        @(negedge clk);
        chk("r1_gnt", gnt, 2'b10);
        step();

        // 2: both read every cycle, no lock
        prev = 2'b00;
        for (int i = 0; i < 5; i++) begin
            req = 2'b11; wr = 2'b00; addr0 = 4'(i); addr1 = 4'(i + 8);
            @(negedge clk);
            chk("rr_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) chk("rr_rvalid", rvalid, prev);
            prev = gnt;
            step();
        end
        req = 2'b00;
        @(negedge clk);
        chk("rr_last_rvalid", rvalid, 2'b01);
        step();

        // 3: R1 locked 4-write burst while R0 keeps asking
        req = 2'b11; lock = 2'b10; wr = 2'b10; addr0 = 4'd0;
        for (int k = 0; k < 4; k++) begin
            addr1 = 4'(k); data1 = 7'(10 + k);
            @(negedge clk);
            chk("lock_gnt", gnt, 2'b10);
            step();
        end
        req = 2'b01; lock = 2'b00; wr = 2'b00;
        @(negedge clk);
        chk("lock_exit_gnt", gnt, 2'b00);
        step();
        @(negedge clk);
        chk("after_lock_gnt", gnt, 2'b01);
        step();
        req = 2'b00;
        step();

        // 4: R1 alone reads addr 3
        req = 2'b10; addr1 = 4'd3;
        @(negedge clk);
        chk("r1_rd_gnt", gnt, 2'b10);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("r1_rvalid", rvalid, 2'b10);
        chk("r1_rdata", rdata, 7'd13);
        step();
        // R0 write leaves prio at R1 before the reset test
        req = 2'b01; wr = 2'b01; addr0 = 4'd4; data0 = 7'd7;
        @(negedge clk);
        chk("r0_wr4_gnt", gnt, 2'b01);
        step();

        // 5: reset in the cycle a read is granted
        wr = 2'b00;
        @(negedge clk);
        chk("pre_rst_gnt", gnt, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt, 2'b00);
        chk("async_rst_ram", {ram_wr, ram_addr, ram_data}, '0);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("dropped_rvalid", rvalid, 2'b00);
        step();
        rst_n = 1'b1;
        req = 2'b11; addr0 = 4'd4; addr1 = 4'd3;
        @(negedge clk);
        chk("rel2_gnt", gnt, 2'b00);
        step();
        @(negedge clk);
        chk("rel2_first_gnt", gnt, 2'b01);
        step();
        @(negedge clk);
        chk("rel2_second_gnt", gnt, 2'b10);
        chk("rel2_rvalid", rvalid, 2'b01);
        chk("rel2_rdata", rdata, 7'd7);
        step();
        req = 2'b00;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
